pipelined_barrel_shifter: RTL
=============================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined logarithmic shifter for the datapath/ALU. Supports SLL, SRL, SRA and ROL
//  on a WIDTH-bit operand with a full 32-bit shift amount. Oversize shifts are handled per mode.
//  Registered stages use a valid/ready handshake, so the block sits between the operand-fetch
//  and ALU-result stages with back-pressure and one result per cycle.
// PARAMETERS
//  WIDTH   32  operand/result width; power of two, 8..64
//  STAGES  2   register stages (latency), 1..clog2(WIDTH)
//  LEVELS  clog2(WIDTH)  derived localparam; number of 2:1 shift levels
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand presented this cycle
//  in_ready   out  1      block accepts operand this cycle
//  in_data    in   WIDTH  operand X
//  in_shamt   in   32     shift amount S (unsigned, full 32 bits)
//  in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  shifted result
//  busy       out  1      any stage holds a valid entry
// BEHAVIOUR
//  - Reset (async, rst=1): every stage valid and data register cleared. out_valid=0, out_data=0,
//    busy=0. in_ready reads 1 once rst is low. In-flight entries are dropped and not replayed.
//  - Transfer: input handshake when in_valid&&in_ready; output handshake when out_valid&&out_ready.
//  - Latency: an accepted operand appears on out_data exactly STAGES cycles later when no stall.
//    Throughput is 1 per cycle.
//  - Per-stage ready: rdy[k] = !vld[k] || rdy[k+1]; rdy[STAGES] = out_ready; in_ready = rdy[0].
//    A stalled stage holds its data and valid bit unchanged. No bubbles are inserted while rdy
//    is high. Order is preserved.
//  - Shift levels: level j shifts by 2^j when shamt[j]=1. Levels are split across stages at
//    ceil(LEVELS/STAGES) per stage, and the last stage takes the remainder. Mode, shamt and the
//    oversize flag travel with the data.
//  - Oversize: ovf = |in_shamt[31:LEVELS], evaluated at input.
//    - SLL/SRL with ovf: result 0.
//    - SRA with ovf: result is WIDTH copies of X[WIDTH-1].
//    - ROL ignores ovf and uses shamt mod WIDTH (low LEVELS bits).
//  - Fills: SLL and SRL fill with 0. SRA fills with the sign bit of the original operand.
//    ROL wraps (X[WIDTH-1] to bit 0).
//  - shamt=0: result equals X for all modes. shamt=WIDTH-1 is legal and not oversize.
//  - Simultaneous input and output handshake on a full pipe is allowed. Occupancy is unchanged.
//  - busy = OR of all stage valid bits. It is combinational from registers.
//  - out_data is driven straight from the last-stage data register.
// STRUCTURE
//  - Shared include shifter_defs.vh holds the op-code constants OP_SLL/OP_SRL/OP_SRA/OP_ROL and a
//    CLOG2 function or macro. The ALU decoder includes the same file.
//  - One sub-module, shift_level: combinational single level. It takes the width, the level
//    index j, the op, an enable bit and a sign bit, and produces the shifted data.
//  - The top generates LEVELS shift_level instances, plus STAGES register slices with valid bits
//    and the ready chain.
// TESTING (WIDTH=32, STAGES=2, out_ready=1 unless noted)
//  1. SLL X=0x00000001 S=31 -> out_data=0x80000000 with out_valid two cycles after accept.
//     S=32 -> 0x00000000.
//  2. SRA X=0x80000000 S=40 -> 0xFFFFFFFF. SRL same -> 0x00000000. SRA X=0x80000000 S=4 -> 0xF8000000.
//  3. ROL X=0x80000001 S=33 -> 0x00000003. ROL X=0x12345678 S=0x80000008 -> 0x34567812.
//  4. Back-pressure: 4 back-to-back ops with out_ready=0 for 5 cycles -> exactly 2 accepted,
//     then in_ready=0. After release, all 4 emerge in order, none lost or duplicated.
//  5. Async rst pulse mid-cycle with 2 entries in flight -> out_valid=0, out_data=0 and busy=0
//     immediately, without waiting for a clock edge. Those entries never appear. A new op after
//     reset completes with latency 2.
//  6. Random regression vs reference model: all ops, S in {0,1,WIDTH-1,WIDTH,2^32-1} plus random,
//     random out_ready -> zero mismatches over 10k ops.
//     Repeat with STAGES=1 and STAGES=5 and with WIDTH=8 and WIDTH=64.

Source files
------------

// File: rtl/pipelined_barrel_shifter_pkg.sv
// pipelined_barrel_shifter_pkg: op-code constants and sizing helpers shared by the shifter and the ALU decoder
package pipelined_barrel_shifter_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// shift_level: one combinational 2:1 level of the log shifter, shifting by 2**J when enabled
module shift_level
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int J     = 0
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       op_i,
  input  logic             en_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] d_o
);
  localparam int A = 1 << J;
  logic fill;
  assign fill = (op_i == OP_SRA) && sign_i;
  assign d_o = !en_i ? d_i :
               op_i == OP_SLL ? {d_i[WIDTH-A-1:0], {A{1'b0}}} :
               op_i == OP_ROL ? {d_i[WIDTH-A-1:0], d_i[WIDTH-1:WIDTH-A]} :
                                {{A{fill}}, d_i[WIDTH-1:A]};
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA/ROL log shifter split over STAGES valid/ready register slices
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [31:0]      in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int PER    = ceil_div(LEVELS, STAGES);
  localparam int MW     = LEVELS + 3;
  logic [STAGES-1:0] vld_q, vld_d, rdy;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  sh_in  [STAGES];
  logic [MW-1:0]     meta_q [STAGES];
  logic [MW-1:0]     meta_d [STAGES];
  logic              ovf;
  assign ovf = |in_shamt[31:LEVELS];
  // Oversize SLL/SRL/SRA collapse to a constant operand up front; later levels leave it unchanged.
  always_comb begin
    vld_d[0]  = in_valid;
    sh_in[0]  = (ovf && in_op != OP_ROL) ? {WIDTH{in_op == OP_SRA && in_data[WIDTH-1]}} : in_data;
    meta_d[0] = {in_op, in_data[WIDTH-1], in_shamt[LEVELS-1:0]};
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      sh_in[k]  = data_q[k-1];
      meta_d[k] = meta_q[k-1];
    end
  end
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !vld_q[k] || r;
      rdy[k] = r;
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PER:0][WIDTH-1:0] ch;
    assign ch[0] = sh_in[k];
    for (genvar i = 0; i < PER; i++) begin : g_lvl
      if (k * PER + i < LEVELS) begin : g_on
        shift_level #(.WIDTH(WIDTH), .J(k * PER + i)) u_lvl (
          .d_i   (ch[i]),
          .op_i  (meta_d[k][MW-1 -: 2]),
          .en_i  (meta_d[k][k * PER + i]),
          .sign_i(meta_d[k][LEVELS]),
          .d_o   (ch[i+1])
        );
      end else begin : g_off
        assign ch[i+1] = ch[i];
      end
    end
    assign data_d[k] = ch[PER];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        meta_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            data_q[k] <= data_d[k];
            meta_q[k] <= meta_d[k];
          end
        end
      end
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |vld_q;
endmodule
